// File: rtl/div_pkg.sv
// Shared types and constants for the divider request sequencer.
// The state enum and the divide-by-zero bypass pattern live here.
package div_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StArm,
        StWait,
        StResp
    } state_e;

    localparam int unsigned MaxN = 32;

    // Sliced to N bits at the use site.
    localparam logic [MaxN-1:0] BypassQuotAllOnes = '1;

endpackage

// File: rtl/div_sequencer_if.sv
// Request, divider-side and response signals of div_sequencer.
// slave is the sequencer view; master is the surrounding environment view.
interface div_sequencer_if #(
    parameter int unsigned N = 4
) ();

    logic           req_valid;
    logic           req_ready;
    logic [N-1:0]   req_dividend;
    logic [N-1:0]   req_divisor;

    logic [N-1:0]   div_dividend;
    logic [N-1:0]   div_divisor;
    logic           div_start_n;
    logic [N-1:0]   div_quotient;
    logic [2*N-1:0] div_remainder;
    logic           div_done;
    logic           div_error;

    logic           rsp_valid;
    logic           rsp_ready;
    logic [N-1:0]   rsp_quotient;
    logic [2*N-1:0] rsp_remainder;
    logic           rsp_error;

    modport slave (
        input  req_valid, req_dividend, req_divisor,
        output req_ready,
        output div_dividend, div_divisor, div_start_n,
        input  div_quotient, div_remainder, div_done, div_error,
        output rsp_valid, rsp_quotient, rsp_remainder, rsp_error,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_dividend, req_divisor,
        input  req_ready,
        input  div_dividend, div_divisor, div_start_n,
        output div_quotient, div_remainder, div_done, div_error,
        input  rsp_valid, rsp_quotient, rsp_remainder, rsp_error,
        output rsp_ready
    );

endinterface

// File: rtl/div_req_fifo.sv
// In-order request FIFO; pointers carry a wrap bit so full/empty need no counter.
// Push is ignored when full and pop when empty.
module div_req_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [Width-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [Width-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(Depth):0] count_o
);

    localparam int unsigned AddrW = $clog2(Depth);

    logic [AddrW:0]   wr_ptr_q, wr_ptr_d;
    logic [AddrW:0]   rd_ptr_q, rd_ptr_d;
    logic [Width-1:0] mem_q [Depth];
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full_o   = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
        empty_o  = (wr_ptr_q == rd_ptr_q);
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q + {{AddrW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AddrW{1'b0}}, do_pop};
        count_o  = wr_ptr_q - rd_ptr_q;
        rdata_o  = mem_q[rd_ptr_q[AddrW-1:0]];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/div_sequencer.sv
// Buffers division requests and issues them one at a time to the iterative divider.
// Optional DIV_ZERO_BYPASS_EN answers divide-by-zero requests locally without issuing.
module div_sequencer
    import div_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    div_sequencer_if.slave  bus,
    output logic            busy
);

    state_e                 state_q, state_d;
    logic [N-1:0]           opa_q, opa_d;
    logic [N-1:0]           opb_q, opb_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [N-1:0]           rsp_quot_q, rsp_quot_d;
    logic [2*N-1:0]         rsp_rem_q, rsp_rem_d;
    logic                   rsp_err_q, rsp_err_d;

    logic                   fifo_pop;
    logic [2*N-1:0]         fifo_rdata;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [N-1:0]           head_dividend;
    logic [N-1:0]           head_divisor;

    div_req_fifo #(
        .Width (2 * N),
        .Depth (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (bus.req_valid),
        .wdata_i ({bus.req_dividend, bus.req_divisor}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign head_dividend = fifo_rdata[2*N-1:N];
    assign head_divisor  = fifo_rdata[N-1:0];

    always_comb begin
        state_d     = state_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_quot_d  = rsp_quot_q;
        rsp_rem_d   = rsp_rem_q;
        rsp_err_d   = rsp_err_q;
        fifo_pop    = 1'b0;

        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    opa_d    = head_dividend;
                    opb_d    = head_divisor;
`ifdef DIV_ZERO_BYPASS_EN
                    if (head_divisor == '0) begin
                        rsp_valid_d = 1'b1;
                        rsp_quot_d  = BypassQuotAllOnes[N-1:0];
                        rsp_rem_d   = {{N{1'b0}}, head_dividend};
                        rsp_err_d   = 1'b1;
                        state_d     = StResp;
                    end else begin
                        state_d = StStart;
                    end
`else
                    state_d = StStart;
`endif
                end
            end
            StStart: state_d = StArm;
            // done may still be high from the previous operation here.
            StArm:   state_d = StWait;
            StWait: begin
                if (bus.div_done) begin
                    rsp_valid_d = 1'b1;
                    rsp_quot_d  = bus.div_quotient;
                    rsp_rem_d   = bus.div_remainder;
                    rsp_err_d   = bus.div_error;
                    state_d     = StResp;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            opa_q       <= '0;
            opb_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_quot_q  <= '0;
            rsp_rem_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_quot_q  <= rsp_quot_d;
            rsp_rem_q   <= rsp_rem_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready     = !fifo_full;
    assign bus.div_dividend  = opa_q;
    assign bus.div_divisor   = opb_q;
    assign bus.div_start_n   = (state_q != StStart);
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_quotient  = rsp_quot_q;
    assign bus.rsp_remainder = rsp_rem_q;
    assign bus.rsp_error     = rsp_err_q;
    assign busy              = (state_q != StIdle) || (fifo_count != '0);

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer with a behavioural divider whose done stays
// high until one cycle after the next start, so a stale done is visible in ARM.
module tb_div_sequencer;

    localparam int unsigned N     = 4;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy;
    int   n_cmp = 0;
    int   n_err = 0;
    int   start_lows = 0;

    div_sequencer_if #(.N(N)) bus ();

    div_sequencer #(
        .N     (N),
        .DEPTH (DEPTH)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    // Divider model: result appears four edges after start is sampled low.
    logic [N-1:0]   m_a = '0;
    logic [N-1:0]   m_b = '0;
    logic [N-1:0]   m_q = '0;
    logic [2*N-1:0] m_r = '0;
    logic           m_e = 1'b0;
    logic           m_done = 1'b0;
    int             m_cnt = 0;

    assign bus.div_quotient  = m_q;
    assign bus.div_remainder = m_r;
    assign bus.div_error     = m_e;
    assign bus.div_done      = m_done;

    always @(posedge clk) begin
        if (!bus.div_start_n) begin
            m_a   <= bus.div_dividend;
            m_b   <= bus.div_divisor;
            m_cnt <= 4;
        end else if (m_cnt == 4) begin
            m_done <= 1'b0;
            m_cnt  <= 3;
        end else if (m_cnt > 1) begin
            m_cnt <= m_cnt - 1;
        end else if (m_cnt == 1) begin
            m_done <= 1'b1;
            m_cnt  <= 0;
            if (m_b == '0) begin
                m_q <= '1;
                m_r <= {{N{1'b0}}, m_a};
                m_e <= 1'b1;
            end else begin
                m_q <= m_a / m_b;
                m_r <= {{N{1'b0}}, m_a % m_b};
                m_e <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst && !bus.div_start_n) start_lows <= start_lows + 1;
    end

    typedef struct packed {
        logic [N-1:0]   q;
        logic [2*N-1:0] r;
        logic           e;
    } rsp_t;

    rsp_t got[$];

    always @(posedge clk) begin
        if (rst && bus.rsp_valid && bus.rsp_ready) begin
            got.push_back({bus.rsp_quotient, bus.rsp_remainder, bus.rsp_error});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b);
        int i;
        bus.req_dividend = a;
        bus.req_divisor  = b;
        bus.req_valid    = 1'b1;
        i = 0;
        while (!bus.req_ready && i < 200) begin
            @(negedge clk);
            i++;
        end
        chk("req_accept", {31'd0, bus.req_ready}, 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_got(input int n, input int max);
        int i;
        i = 0;
        while (got.size() < n && i < max) begin
            @(negedge clk);
            i++;
        end
        chk("rsp_count", got.size(), n);
    endtask

    task automatic chk_rsp(input string tag, input int idx, input logic [N-1:0] q,
                           input logic [2*N-1:0] r, input logic e);
        rsp_t x;
        x = (idx < got.size()) ? got[idx] : '0;
        chk({tag, "_q"}, {28'd0, x.q}, {28'd0, q});
        chk({tag, "_r"}, {24'd0, x.r}, {24'd0, r});
        chk({tag, "_e"}, {31'd0, x.e}, {31'd0, e});
    endtask

    logic [N-1:0]   fill_a [6] = '{4'd15, 4'd6, 4'd12, 4'd9, 4'd14, 4'd8};
    logic [N-1:0]   fill_b [6] = '{4'd7, 4'd2, 4'd5, 4'd4, 4'd3, 4'd3};
    logic [N-1:0]   fill_q [6] = '{4'd2, 4'd3, 4'd2, 4'd2, 4'd4, 4'd2};
    logic [2*N-1:0] fill_r [6] = '{8'd1, 8'd0, 8'd2, 8'd1, 8'd2, 8'd2};

    initial begin
        int s0;
        int i;
        bus.req_valid    = 1'b0;
        bus.req_dividend = '0;
        bus.req_divisor  = '0;
        bus.rsp_ready    = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_start_n", {31'd0, bus.div_start_n}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_dividend", {28'd0, bus.div_dividend}, 32'd0);
        chk("rst_divisor", {28'd0, bus.div_divisor}, 32'd0);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_q", {28'd0, bus.rsp_quotient}, 32'd0);
        chk("rst_rsp_r", {24'd0, bus.rsp_remainder}, 32'd0);
        chk("rst_rsp_e", {31'd0, bus.rsp_error}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Single request 15/7 with issue timing
        bus.rsp_ready = 1'b1;
        got.delete();
        s0 = start_lows;
        send(4'd15, 4'd7);
        chk("single_pre_issue", {31'd0, bus.div_start_n}, 32'd1);
        @(negedge clk);
        chk("single_start_low", {31'd0, bus.div_start_n}, 32'd0);
        chk("single_op_a", {28'd0, bus.div_dividend}, 32'd15);
        chk("single_op_b", {28'd0, bus.div_divisor}, 32'd7);
        @(negedge clk);
        chk("single_start_high", {31'd0, bus.div_start_n}, 32'd1);
        wait_got(1, 30);
        chk_rsp("single", 0, 4'd2, 8'd1, 1'b0);
        chk("single_valid_drop", {31'd0, bus.rsp_valid}, 32'd0);
        chk("single_one_pulse", start_lows - s0, 32'd1);

        // Stale done: second issue starts while done is still high
        got.delete();
        send(4'd15, 4'd7);
        send(4'd6, 4'd2);
        wait_got(2, 60);
        chk_rsp("stale0", 0, 4'd2, 8'd1, 1'b0);
        chk_rsp("stale1", 1, 4'd3, 8'd0, 1'b0);

        // Backpressure: 12/5 held ten cycles
        bus.rsp_ready = 1'b0;
        got.delete();
        s0 = start_lows;
        send(4'd12, 4'd5);
        i = 0;
        while (!bus.rsp_valid && i < 30) begin
            @(negedge clk);
            i++;
        end
        for (int k = 0; k < 10; k++) begin
            chk("bp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            chk("bp_q", {28'd0, bus.rsp_quotient}, 32'd2);
            chk("bp_r", {24'd0, bus.rsp_remainder}, 32'd2);
            @(negedge clk);
        end
        chk("bp_no_extra_start", start_lows - s0, 32'd1);
        bus.rsp_ready = 1'b1;
        wait_got(1, 5);
        chk_rsp("bp", 0, 4'd2, 8'd2, 1'b0);

        // FIFO fill: one issued, four buffered, sixth stalls
        bus.rsp_ready = 1'b0;
        got.delete();
        for (int k = 0; k < 5; k++) send(fill_a[k], fill_b[k]);
        chk("fill_full", {31'd0, bus.req_ready}, 32'd0);
        chk("fill_busy", {31'd0, busy}, 32'd1);
        bus.req_dividend = fill_a[5];
        bus.req_divisor  = fill_b[5];
        bus.req_valid    = 1'b1;
        repeat (3) @(negedge clk);
        chk("fill_still_full", {31'd0, bus.req_ready}, 32'd0);
        bus.rsp_ready = 1'b1;
        send(fill_a[5], fill_b[5]);
        wait_got(6, 200);
        for (int k = 0; k < 6; k++) chk_rsp("fill", k, fill_q[k], fill_r[k], 1'b0);

        // Divide by zero
        got.delete();
        s0 = start_lows;
        send(4'd9, 4'd0);
        wait_got(1, 30);
        chk_rsp("dz", 0, 4'hF, 8'd9, 1'b1);
`ifdef DIV_ZERO_BYPASS_EN
        chk("dz_pulses", start_lows - s0, 32'd0);
`else
        chk("dz_pulses", start_lows - s0, 32'd1);
`endif

        // Reset during WAIT, then 8/3
        repeat (2) @(negedge clk);
        got.delete();
        send(4'd13, 4'd5);
        repeat (3) @(negedge clk);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("mid_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("mid_busy_clr", {31'd0, busy}, 32'd0);
        chk("mid_start_n", {31'd0, bus.div_start_n}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        send(4'd8, 4'd3);
        wait_got(1, 40);
        repeat (10) @(negedge clk);
        chk("mid_only_one", got.size(), 32'd1);
        chk_rsp("mid", 0, 4'd2, 8'd2, 1'b0);
        chk("end_busy", {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
